// File: rtl/rollout_scheduler.sv
// Purpose: time-shares one rollout engine across UP/DOWN/LEFT/RIGHT, round-robin, and reports the best-scoring legal direction.
// Latency: best_valid at start + ROLLOUTS*popcount(legal)*(L+2) + 2 for engine latency L; start + 1 when legal == 0.
// Backpressure: one rollout in flight; eng_start is not re-issued before eng_done (or watchdog expiry); start is ignored while busy.
// Optional feature: define ROLLOUT_TIMEOUT_EN to build the WAIT watchdog (TIMEOUT cycles) and timeout_flag.
module rollout_scheduler #(
  parameter int ROLLOUTS = 16,
  parameter int SCORE_W  = 31,
  parameter int ACC_W    = 40,
  parameter int TIMEOUT  = 4096
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [255:0]       i_cand_boards,
  input  logic [3:0]         i_legal,
  output logic               o_eng_start,
  output logic [63:0]        o_eng_board,
  input  logic               i_eng_done,
  input  logic [SCORE_W-1:0] i_eng_score,
  output logic               o_busy,
  output logic               o_best_valid,
  output logic [2:0]         o_best_dir,
  output logic               o_timeout_flag
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_ACCUM  = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Comparison order for the decision: the earlier entry wins a tie (DOWN, UP, LEFT, RIGHT).
  localparam logic [7:0] TIE_ORDER = {2'd3, 2'd2, 2'd0, 2'd1};

  state_t             r_state;
  state_t             w_next;
  logic [255:0]       r_boards;
  logic [3:0]         r_legal;
  logic [ACC_W-1:0]   r_acc [4];
  logic [7:0]         r_round;
  logic [1:0]         r_ptr;
  logic [1:0]         r_dir;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_best_dir;

  logic [1:0]         w_sel;
  logic               w_found;
  logic [1:0]         w_idx;
  logic [1:0]         w_last_dir;
  logic               w_last_round;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_acc_new;
  logic [2:0]         w_best_dir;
  logic [ACC_W-1:0]   w_best_acc;
  logic               w_have;
  logic [1:0]         w_cand;
  logic               w_timeout;

  // Next legal direction at or after the pointer, wrapping past RIGHT back to UP.
  always_comb begin
    w_sel   = r_ptr;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && r_legal[w_idx]) begin
        w_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  // Highest legal direction closes a round; saturating add of the captured score.
  always_comb begin
    w_last_dir = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (r_legal[i]) w_last_dir = 2'(i);
    end
    w_last_round = (r_dir == w_last_dir) && ((r_round + 8'd1) == 8'(ROLLOUTS));
    w_sum        = {1'b0, r_acc[r_dir]} + (ACC_W+1)'(r_score);
    w_acc_new    = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  end

  // Pick the maximum accumulator among legal directions; strict compare keeps the tie winner.
  always_comb begin
    w_best_dir = 3'd0;
    w_best_acc = '0;
    w_have     = 1'b0;
    w_cand     = 2'd0;
    for (int j = 0; j < 4; j++) begin
      w_cand = TIE_ORDER[j*2 +: 2];
      if (r_legal[w_cand] && (!w_have || (r_acc[w_cand] > w_best_acc))) begin
        w_have     = 1'b1;
        w_best_acc = r_acc[w_cand];
        w_best_dir = {1'b0, w_cand} + 3'd1;
      end
    end
  end

`ifdef ROLLOUT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] r_wd;
  logic            r_tflag;

  assign w_timeout      = (r_state == S_WAIT) && !i_eng_done && (r_wd == WD_W'(TIMEOUT - 1));
  assign o_timeout_flag = r_tflag;

  // Watchdog counts WAIT cycles of the current rollout; the flag stays set until the next accepted start.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd    <= '0;
      r_tflag <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wd <= '0;
      else if (r_state == S_WAIT) r_wd <= r_wd + WD_W'(1);
      if (r_state == S_IDLE && i_start) r_tflag <= 1'b0;
      else if (w_timeout)               r_tflag <= 1'b1;
    end
  end
`else
  assign w_timeout      = 1'b0;
  assign o_timeout_flag = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs; the board is only driven alongside eng_start.
  always_comb begin
    w_next       = r_state;
    o_eng_start  = 1'b0;
    o_eng_board  = '0;
    o_busy       = (r_state != S_IDLE);
    o_best_valid = 1'b0;
    case (r_state)
      S_IDLE:   if (i_start) w_next = (i_legal == 4'b0000) ? S_DONE : S_ISSUE;
      S_ISSUE: begin
        o_eng_start = 1'b1;
        o_eng_board = r_boards[{w_sel, 6'b0} +: 64];
        w_next      = S_WAIT;
      end
      S_WAIT:   if (i_eng_done || w_timeout) w_next = S_ACCUM;
      S_ACCUM:  w_next = w_last_round ? S_DECIDE : S_ISSUE;
      S_DECIDE: w_next = S_DONE;
      S_DONE: begin
        o_best_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  assign o_best_dir = r_best_dir;

  // Datapath: latch the request, track the rollout pointer, capture and accumulate scores, record the winner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_boards   <= '0;
      r_legal    <= 4'b0000;
      r_round    <= 8'd0;
      r_ptr      <= 2'd0;
      r_dir      <= 2'd0;
      r_score    <= '0;
      r_best_dir <= 3'd0;
      for (int i = 0; i < 4; i++) r_acc[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_boards   <= i_cand_boards;
            r_legal    <= i_legal;
            r_round    <= 8'd0;
            r_ptr      <= 2'd0;
            r_best_dir <= 3'd0;
            for (int i = 0; i < 4; i++) r_acc[i] <= '0;
          end
        end
        S_ISSUE: begin
          r_dir <= w_sel;
          r_ptr <= w_sel + 2'd1;
        end
        S_WAIT: begin
          if (i_eng_done)     r_score <= i_eng_score;
          else if (w_timeout) r_score <= '0;
        end
        S_ACCUM: begin
          r_acc[r_dir] <= w_acc_new;
          if (r_dir == w_last_dir) r_round <= r_round + 8'd1;
        end
        S_DECIDE: r_best_dir <= w_best_dir;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rollout_scheduler.sv
// Bench for rollout_scheduler: table of directed decisions plus hand sequences for reset, saturation and watchdog.
// A behavioural engine answers each eng_start after a fixed latency with a per-direction score.
module tb_rollout_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] cand_boards;
  logic [3:0]   legal;
  logic         eng_start;
  logic [63:0]  eng_board;
  logic         eng_done;
  logic [30:0]  eng_score;
  logic         busy;
  logic         best_valid;
  logic [2:0]   best_dir;
  logic         timeout_flag;

  rollout_scheduler #(.ROLLOUTS(16), .SCORE_W(31), .ACC_W(32), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_cand_boards(cand_boards), .i_legal(legal),
    .o_eng_start(eng_start), .o_eng_board(eng_board), .i_eng_done(eng_done), .i_eng_score(eng_score),
    .o_busy(busy), .o_best_valid(best_valid), .o_best_dir(best_dir), .o_timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Engine model state
  int          e_lat = 1;
  logic [30:0] e_sc [4];
  logic [3:0]  e_mute = 4'b0000;
  bit          e_sat = 1'b0;
  logic [3:0]  e_legal_exp = 4'b0000;
  int          e_cnt_dir [4];
  bit          e_pend = 1'b0;
  int          e_cnt = 0;
  logic [30:0] e_pend_score = '0;
  int          n_starts = 0;
  int          bad = 0;
  int          ord [0:1023];

  // Engine: answers eng_done exactly e_lat cycles after eng_start; flags unknown/illegal boards and overlapping starts.
  initial begin
    eng_done  = 1'b0;
    eng_score = '0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (e_pend) begin
        e_cnt--;
        if (e_cnt == 0) begin
          eng_done  = 1'b1;
          eng_score = e_pend_score;
          e_pend    = 1'b0;
        end
      end
      if (eng_start) begin
        int d;
        logic [30:0] sc;
        d = -1;
        for (int k = 0; k < 4; k++) if (eng_board == cand_boards[k*64 +: 64]) d = k;
        if (d < 0 || e_pend) bad++;
        else if (!e_legal_exp[d]) bad++;
        else begin
          if (n_starts < 1024) ord[n_starts] = d;
          if (e_sat && d == 2) sc = (e_cnt_dir[2] < 15) ? 31'd268435456 : 31'd268435448;
          else                 sc = e_sc[d];
          e_cnt_dir[d]++;
          if (!e_mute[d]) begin
            e_pend       = 1'b1;
            e_cnt        = e_lat;
            e_pend_score = sc;
          end
        end
        n_starts++;
      end
    end
  end

  // One decision: pulse start, optionally poke start/legal mid-run, wait (bounded) for best_valid.
  task automatic run_dec(input logic [3:0] lg, input int lat, input int su, input int sd, input int sl,
                         input int sr, input logic [3:0] mute, input bit sat, input bit poke,
                         output int lat_obs, output bit got);
    int t0;
    legal       = lg;
    e_legal_exp = lg;
    e_lat       = lat;
    e_sc[0] = 31'(su); e_sc[1] = 31'(sd); e_sc[2] = 31'(sl); e_sc[3] = 31'(sr);
    e_mute = mute;
    e_sat  = sat;
    n_starts = 0;
    bad      = 0;
    for (int i = 0; i < 4; i++) e_cnt_dir[i] = 0;
    got     = 1'b0;
    lat_obs = -1;
    @(negedge clk);
    start = 1'b1;
    t0    = cyc;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && n == 20) begin
        start = 1'b1;
        legal = 4'b1111;
      end
      if (best_valid) begin
        got     = 1'b1;
        lat_obs = cyc - t0;
      end
    end
    start = 1'b0;
    legal = lg;
  endtask

  function automatic int order_errs(input logic [3:0] lg);
    int bits [4];
    int k = 0;
    int e = 0;
    for (int i = 0; i < 4; i++) if (lg[i]) begin bits[k] = i; k++; end
    for (int i = 0; i < n_starts && i < 1024; i++) if (k == 0 || ord[i] != bits[i % k]) e++;
    return e;
  endfunction

  typedef struct {
    logic [3:0] legal;
    int         lat;
    int         su, sd, sl, sr;
    logic [2:0] exp_dir;
    int         exp_lat;
    int         exp_starts;
  } vec_t;

  vec_t vt [7];

  initial begin
    int  lat_obs;
    bit  got;
    int  noise;
    logic [3:0] nib;

    vt[0] = '{4'b1111, 3, 10, 20,   5, 7, 3'd2, 322, 64};
    vt[1] = '{4'b0101, 2,  9,  9,   9, 9, 3'd1, 130, 32};
    vt[2] = '{4'b0000, 1,  1,  1,   1, 1, 3'd0,   1,  0};
    vt[3] = '{4'b1000, 1,  0,  0,   0, 0, 3'd4,  50, 16};
    vt[4] = '{4'b1010, 1, 100, 3, 100, 3, 3'd2,  98, 32};
    vt[5] = '{4'b1101, 2,  4, 99,   6, 6, 3'd3, 194, 48};
    vt[6] = '{4'b0011, 1,  8,  7,   0, 0, 3'd1,  98, 32};

    for (int d = 0; d < 4; d++) begin
      nib = 4'(d + 1);
      cand_boards[d*64 +: 64] = {16{nib}};
    end
    for (int i = 0; i < 4; i++) begin e_sc[i] = '0; e_cnt_dir[i] = 0; end
    rst   = 1'b1;
    start = 1'b0;
    legal = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_busy",       int'(busy), 0);
    check("rst_best_valid", int'(best_valid), 0);
    check("rst_eng_start",  int'(eng_start), 0);
    check("rst_best_dir",   int'(best_dir), 0);
    check("rst_timeout",    int'(timeout_flag), 0);
    check("rst_eng_board",  int'(eng_board != 64'd0), 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven decisions
    for (int v = 0; v < 7; v++) begin
      run_dec(vt[v].legal, vt[v].lat, vt[v].su, vt[v].sd, vt[v].sl, vt[v].sr, 4'b0000, 1'b0, 1'b0, lat_obs, got);
      check($sformatf("v%0d_done", v),     int'(got), 1);
      check($sformatf("v%0d_latency", v),  lat_obs, vt[v].exp_lat);
      check($sformatf("v%0d_best_dir", v), int'(best_dir), int'(vt[v].exp_dir));
      check($sformatf("v%0d_starts", v),   n_starts, vt[v].exp_starts);
      check($sformatf("v%0d_order", v),    order_errs(vt[v].legal), 0);
      check($sformatf("v%0d_bad_board", v), bad, 0);
      @(negedge clk);
      check($sformatf("v%0d_idle_after", v), int'({busy, best_valid}), 0);
      check($sformatf("v%0d_dir_held", v),   int'(best_dir), int'(vt[v].exp_dir));
      repeat (3) @(negedge clk);
    end

    // Saturation: DOWN gets 16 x (2^31-1) and must clamp at 2^32-1, beating LEFT's 2^32-8.
    // A mid-run start with legal=1111 must be ignored.
    run_dec(4'b0110, 1, 0, 2147483647, 0, 0, 4'b0000, 1'b1, 1'b1, lat_obs, got);
    check("sat_done",     int'(got), 1);
    check("sat_latency",  lat_obs, 98);
    check("sat_best_dir", int'(best_dir), 2);
    check("sat_starts",   n_starts, 32);
    check("sat_order",    order_errs(4'b0110), 0);
    check("sat_bad",      bad, 0);
    repeat (5) @(negedge clk);
    check("sat_dir_held", int'(best_dir), 2);

    // Reset in the middle of WAIT aborts; nothing is emitted until the next start.
    legal = 4'b1111; e_legal_exp = 4'b1111; e_lat = 3; e_sat = 1'b0; bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_wait_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", int'({busy, best_valid, eng_start, best_dir}), 0);
    rst   = 1'b0;
    noise = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (busy || best_valid || eng_start) noise++;
    end
    check("rst_mid_quiet", noise, 0);

    // Engine never answers LEFT.
`ifdef ROLLOUT_TIMEOUT_EN
    run_dec(4'b1111, 1, 1, 2, 50, 3, 4'b0100, 1'b0, 1'b0, lat_obs, got);
    check("to_done",      int'(got), 1);
    check("to_latency",   lat_obs, 306);
    check("to_best_dir",  int'(best_dir), 4);
    check("to_left_runs", e_cnt_dir[2], 16);
    @(negedge clk);
    check("to_flag_set",  int'(timeout_flag), 1);
    run_dec(4'b0001, 1, 5, 0, 0, 0, 4'b0000, 1'b0, 1'b0, lat_obs, got);
    check("to_flag_clear", int'(timeout_flag), 0);
    check("to_next_dir",   int'(best_dir), 1);
`else
    run_dec(4'b1111, 1, 1, 2, 50, 3, 4'b0100, 1'b0, 1'b0, lat_obs, got);
    check("nto_no_result", int'(got), 0);
    check("nto_busy",      int'(busy), 1);
    check("nto_flag",      int'(timeout_flag), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("nto_recovered", int'(busy), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
